// File: rtl/blip_pkg.sv
// blip_pkg: shared types and constants for the multi-channel blip generator.
//   blip_state_e : per-channel FSM state (2 bits)
//   NOTE_W       : width of one MIDI note number
package blip_pkg;

  localparam int NOTE_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    DONE  = 2'd3
  } blip_state_e;

endpackage

// File: rtl/blip_gen_multi_if.sv
// blip_gen_multi_if: bundle between the MIDI voice allocator (master) and the
// blip generator (slave). Channel n occupies slice n of every vector.
//   note_on     master->slave  CHANNELS        per-channel gate
//   note_repeat master->slave  CHANNELS        per-channel retrigger request
//   note        master->slave  7*CHANNELS      MIDI note, ch n at [7n+6:7n]
//   level       master->slave  OUT_W*CHANNELS  pulse amplitude, sampled at trigger
//   blip_out    slave->master  OUT_W*CHANNELS  registered output sample
//   active      slave->master  CHANNELS        registered, 1 in DELAY or HIGH
//   state_dbg   slave->master  2*CHANNELS      FSM state per channel (blip_state_e)
//
// Handshake: there is no valid/ready pair. All master signals are levels
// sampled on every enabled rising edge; a trigger is the note_on level
// combined with a note change or a note_repeat level, so the master never
// waits and the slave never back-pressures.
interface blip_gen_multi_if #(
  parameter int CHANNELS = 4,
  parameter int OUT_W    = 4
);

  logic [CHANNELS-1:0]                 note_on;
  logic [CHANNELS-1:0]                 note_repeat;
  logic [blip_pkg::NOTE_W*CHANNELS-1:0] note;
  logic [OUT_W*CHANNELS-1:0]           level;
  logic [OUT_W*CHANNELS-1:0]           blip_out;
  logic [CHANNELS-1:0]                 active;
  logic [2*CHANNELS-1:0]               state_dbg;

  modport master (
    output note_on, note_repeat, note, level,
    input  blip_out, active, state_dbg
  );

  modport slave (
    input  note_on, note_repeat, note, level,
    output blip_out, active, state_dbg
  );

endinterface

// File: rtl/blip_chan.sv
// blip_chan: one blip channel. Watches a note gate, waits DELAY_CYC enabled
// clocks after a trigger, then holds blip_out at the sampled level for
// PULSE_CYC enabled clocks.
// Optional feature macro: BLIP_DECAY_EN (amplitude decays during HIGH).
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   en            global enable; low forces blip_out to 0 and freezes state
//   note_on       gate
//   note_repeat   retrigger request
//   note          MIDI note number
//   level         amplitude, captured at trigger
//   blip_out      registered sample
//   active        registered, 1 while in DELAY or HIGH
//   state         current FSM state (debug)
// Timing: inputs presented after edge t are first sampled at edge t+1, so
// blip_out carries the amplitude from edge t+DELAY_CYC+1.
module blip_chan
  import blip_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int DELAY_CYC = 1048575,
  parameter int PULSE_CYC = 1048576,
  parameter int OUT_W     = 4,
  parameter int DECAY_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              note_on,
  input  logic              note_repeat,
  input  logic [NOTE_W-1:0] note,
  input  logic [OUT_W-1:0]  level,
  output logic [OUT_W-1:0]  blip_out,
  output logic              active,
  output blip_state_e       state
);

  // One extra bit so PULSE_CYC = 2^CNT_W is representable without wrap.
  localparam int CW = CNT_W + 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] PLS_LAST = CW'(PULSE_CYC - 1);

  if (DELAY_CYC < 1 || PULSE_CYC < 1 || DECAY_CYC < 1) begin : g_param_check
    $error("blip_chan: DELAY_CYC, PULSE_CYC and DECAY_CYC must be >= 1");
  end

  blip_state_e       state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              rep_q, rep_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]  amp_q, amp_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              act_q, act_d;
  logic              trigger;

`ifdef BLIP_DECAY_EN
  localparam int DW = $clog2(DECAY_CYC) + 1;
  localparam logic [DW-1:0] DCY_LAST = DW'(DECAY_CYC - 1);
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [OUT_W-1:0] amp_dec;
`endif

  // A held note re-evaluated from DONE does not retrigger: it needs a new
  // note value, a pending repeat, or a live repeat request.
  assign trigger = note_on && ((note != note_q) || rep_q || note_repeat);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      note_q  <= '0;
      rep_q   <= 1'b0;
      cnt_q   <= '0;
      amp_q   <= '0;
      out_q   <= '0;
      act_q   <= 1'b0;
`ifdef BLIP_DECAY_EN
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      amp_q   <= amp_d;
      out_q   <= out_d;
      act_q   <= act_d;
`ifdef BLIP_DECAY_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    amp_d   = amp_q;
    out_d   = out_q;
    act_d   = act_q;
`ifdef BLIP_DECAY_EN
    dcnt_d  = dcnt_q;
    amp_dec = amp_q;
`endif
    if (!en) begin
      // Output muted, everything else frozen so en=1 resumes in place.
      out_d = '0;
    end else if (!note_on) begin
      state_d = IDLE;
      out_d   = '0;
      act_d   = 1'b0;
      note_d  = '0;
      // A repeat arriving while the gate is down for the same note is
      // remembered so the next gate-on retriggers.
      if (note == note_q) rep_d = note_repeat;
    end else if (trigger) begin
      state_d = DELAY;
      note_d  = note;
      amp_d   = level;
      rep_d   = 1'b0;
      cnt_d   = '0;
      out_d   = '0;
      act_d   = 1'b1;
`ifdef BLIP_DECAY_EN
      dcnt_d  = '0;
`endif
    end else begin
      case (state_q)
        DELAY: begin
          if (cnt_q == DLY_LAST) begin
            cnt_d   = '0;
            out_d   = amp_q;
            state_d = HIGH;
`ifdef BLIP_DECAY_EN
            dcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HIGH: begin
`ifdef BLIP_DECAY_EN
          dcnt_d = dcnt_q + 1'b1;
          if (dcnt_q == DCY_LAST) begin
            dcnt_d = '0;
            if (amp_q != '0) amp_dec = amp_q - 1'b1;
          end
          amp_d = amp_dec;
          if (cnt_q == PLS_LAST || amp_dec == '0) begin
            cnt_d   = '0;
            out_d   = '0;
            act_d   = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            out_d = amp_dec;
          end
`else
          if (cnt_q == PLS_LAST) begin
            cnt_d   = '0;
            out_d   = '0;
            act_d   = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            // Re-assert after an en=0 stretch muted the output mid-pulse.
            out_d = amp_q;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign blip_out = out_q;
  assign active   = act_q;
  assign state    = state_q;

endmodule

// File: rtl/blip_gen_multi.sv
// blip_gen_multi: CHANNELS independent blip channels between the MIDI voice
// allocator and the audio mixer. Each channel delays DELAY_CYC enabled clocks
// after a new note or repeat, then emits one PULSE_CYC-long amplitude pulse.
// Optional feature macro: BLIP_DECAY_EN (linear decay of the pulse by one LSB
// every DECAY_CYC clocks; pulse ends early when the amplitude reaches 0).
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset (honoured regardless of en)
//   en     global enable; low = outputs 0, state frozen
//   bus    blip_gen_multi_if.slave: note_on, note_repeat, note, level in;
//          blip_out, active, state_dbg out
module blip_gen_multi
  import blip_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 20,
  parameter int DELAY_CYC = 1048575,
  parameter int PULSE_CYC = 1048576,
  parameter int OUT_W     = 4,
  parameter int DECAY_CYC = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  blip_gen_multi_if.slave bus
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    blip_state_e st;

    blip_chan #(
      .CNT_W     (CNT_W),
      .DELAY_CYC (DELAY_CYC),
      .PULSE_CYC (PULSE_CYC),
      .OUT_W     (OUT_W),
      .DECAY_CYC (DECAY_CYC)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .note_on     (bus.note_on[gi]),
      .note_repeat (bus.note_repeat[gi]),
      .note        (bus.note[NOTE_W*gi +: NOTE_W]),
      .level       (bus.level[OUT_W*gi +: OUT_W]),
      .blip_out    (bus.blip_out[OUT_W*gi +: OUT_W]),
      .active      (bus.active[gi]),
      .state       (st)
    );

    assign bus.state_dbg[2*gi +: 2] = st;
  end

endmodule

// File: tb/tb_blip_gen_multi.sv
// Directed bench for blip_gen_multi with CHANNELS=2, DELAY_CYC=4, PULSE_CYC=3.
// "Edge 0" is the first edge after reset release; stimulus for edge 0 is
// driven 1 ns after it, and outputs after edge k are sampled 1 ns after edge k.
module tb_blip_gen_multi;
  import blip_pkg::*;

  localparam int CH  = 2;
  localparam int OW  = 4;
  localparam int DLY = 4;
  localparam int PLS = 3;

  logic clk = 1'b0;
  logic reset;
  logic en;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  blip_gen_multi_if #(.CHANNELS(CH), .OUT_W(OW)) bus ();

  blip_gen_multi #(
    .CHANNELS(CH), .CNT_W(20), .DELAY_CYC(DLY), .PULSE_CYC(PLS),
    .OUT_W(OW), .DECAY_CYC(4096)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .bus(bus)
  );

`ifdef BLIP_DECAY_EN
  blip_gen_multi_if #(.CHANNELS(1), .OUT_W(OW)) bus_d ();

  blip_gen_multi #(
    .CHANNELS(1), .CNT_W(20), .DELAY_CYC(DLY), .PULSE_CYC(8),
    .OUT_W(OW), .DECAY_CYC(1)
  ) dut_d (
    .clk(clk), .reset(reset), .en(en), .bus(bus_d)
  );
`endif

  // ---------------- clock / reset helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.note_on     = '0;
    bus.note_repeat = '0;
    bus.note        = '0;
    bus.level       = '0;
`ifdef BLIP_DECAY_EN
    bus_d.note_on     = '0;
    bus_d.note_repeat = '0;
    bus_d.note        = '0;
    bus_d.level       = '0;
`endif
  endtask

  // Leaves the bench 1 ns after edge 0 with all gates low.
  task automatic do_reset();
    drive_idle();
    en    = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_ch0(input logic [6:0] n, input logic [3:0] lv);
    bus.note[6:0]  = n;
    bus.level[3:0] = lv;
    bus.note_on[0] = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    en    = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.blip_out !== 8'h00) $display("FAIL reset_blip_out got %h want 00", bus.blip_out);
    else n_pass++;
    n_checks++;
    if (bus.active !== 2'b00) $display("FAIL reset_active got %b want 00", bus.active);
    else n_pass++;
    n_checks++;
    if (bus.state_dbg !== 4'h0) $display("FAIL reset_state got %h want 0 (IDLE)", bus.state_dbg);
    else n_pass++;
    reset = 1'b0;
  endtask

  // Test 1 followed by test 2: single pulse, then a long hold stays DONE.
  task automatic test_basic_and_hold();
    logic [3:0] exp_o;
    logic       exp_a;
    do_reset();
    start_ch0(7'd60, 4'd12);
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_o = (e >= 5 && e <= 7) ? 4'd12 : 4'd0;
      exp_a = (e <= 7);
      n_checks++;
      if (bus.blip_out[3:0] !== exp_o)
        $display("FAIL basic_out e=%0d got %0d want %0d", e, bus.blip_out[3:0], exp_o);
      else n_pass++;
      n_checks++;
      if (bus.active[0] !== exp_a)
        $display("FAIL basic_active e=%0d got %b want %b", e, bus.active[0], exp_a);
      else n_pass++;
      n_checks++;
      if (bus.blip_out[7:4] !== 4'd0 || bus.active[1] !== 1'b0)
        $display("FAIL basic_ch1_quiet e=%0d got out=%0d act=%b want 0/0", e, bus.blip_out[7:4], bus.active[1]);
      else n_pass++;
    end
    for (int e = 11; e <= 60; e++) begin
      tick();
      n_checks++;
      if (bus.blip_out[3:0] !== 4'd0 || bus.active[0] !== 1'b0)
        $display("FAIL hold_quiet e=%0d got out=%0d act=%b want 0/0", e, bus.blip_out[3:0], bus.active[0]);
      else n_pass++;
    end
    n_checks++;
    if (bus.state_dbg[1:0] !== DONE) $display("FAIL hold_state got %0d want %0d (DONE)", bus.state_dbg[1:0], DONE);
    else n_pass++;
  endtask

  task automatic test_repeat();
    logic [3:0] exp_o;
    logic       exp_a;
    do_reset();
    start_ch0(7'd60, 4'd12);
    for (int e = 1; e <= 16; e++) begin
      tick();
      exp_o = ((e >= 5 && e <= 6) || (e >= 11 && e <= 13)) ? 4'd12 : 4'd0;
      exp_a = (e <= 13);
      n_checks++;
      if (bus.blip_out[3:0] !== exp_o)
        $display("FAIL repeat_out e=%0d got %0d want %0d", e, bus.blip_out[3:0], exp_o);
      else n_pass++;
      n_checks++;
      if (bus.active[0] !== exp_a)
        $display("FAIL repeat_active e=%0d got %b want %b", e, bus.active[0], exp_a);
      else n_pass++;
      bus.note_repeat[0] = (e == 6);
    end
  endtask

  task automatic test_note_change();
    logic [3:0] exp_o0, exp_o1;
    do_reset();
    start_ch0(7'd60, 4'd12);
    bus.note[13:7]  = 7'd64;
    bus.level[7:4]  = 4'd5;
    bus.note_on[1]  = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_o0 = (e >= 8 && e <= 10) ? 4'd12 : 4'd0;
      exp_o1 = (e >= 5 && e <= 7) ? 4'd5 : 4'd0;
      n_checks++;
      if (bus.blip_out[3:0] !== exp_o0)
        $display("FAIL change_out0 e=%0d got %0d want %0d", e, bus.blip_out[3:0], exp_o0);
      else n_pass++;
      n_checks++;
      if (bus.blip_out[7:4] !== exp_o1)
        $display("FAIL change_out1 e=%0d got %0d want %0d", e, bus.blip_out[7:4], exp_o1);
      else n_pass++;
      if (e == 3) bus.note[6:0] = 7'd62;
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_o;
    logic       exp_a;
    do_reset();
    start_ch0(7'd60, 4'd12);
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_o = (e == 5 || e == 16 || e == 17) ? 4'd12 : 4'd0;
      exp_a = (e <= 17);
      n_checks++;
      if (bus.blip_out[3:0] !== exp_o)
        $display("FAIL enable_out e=%0d got %0d want %0d", e, bus.blip_out[3:0], exp_o);
      else n_pass++;
      n_checks++;
      if (bus.active[0] !== exp_a)
        $display("FAIL enable_active e=%0d got %b want %b", e, bus.active[0], exp_a);
      else n_pass++;
      if (e == 5)  en = 1'b0;
      if (e == 15) en = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_o;
    logic       exp_a;
    do_reset();
    start_ch0(7'd60, 4'd12);
    for (int e = 1; e <= 16; e++) begin
      tick();
      exp_o = ((e >= 5 && e <= 6) || (e >= 12 && e <= 14)) ? 4'd12 : 4'd0;
      exp_a = (e <= 6) || (e >= 8 && e <= 14);
      n_checks++;
      if (bus.blip_out[3:0] !== exp_o)
        $display("FAIL rstmid_out e=%0d got %0d want %0d", e, bus.blip_out[3:0], exp_o);
      else n_pass++;
      n_checks++;
      if (bus.active[0] !== exp_a)
        $display("FAIL rstmid_active e=%0d got %b want %b", e, bus.active[0], exp_a);
      else n_pass++;
      reset = (e == 6);
    end
  endtask

  task automatic test_level_zero();
    logic exp_a;
    do_reset();
    start_ch0(7'd33, 4'd0);
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_a = (e <= 7);
      n_checks++;
      if (bus.blip_out[3:0] !== 4'd0 || bus.active[0] !== exp_a)
        $display("FAIL level0 e=%0d got out=%0d act=%b want 0/%b", e, bus.blip_out[3:0], bus.active[0], exp_a);
      else n_pass++;
    end
  endtask

`ifdef BLIP_DECAY_EN
  task automatic test_decay();
    logic [3:0] exp_o;
    do_reset();
    bus_d.note    = 7'd60;
    bus_d.level   = 4'd3;
    bus_d.note_on = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_o = (e == 5) ? 4'd3 : (e == 6) ? 4'd2 : (e == 7) ? 4'd1 : 4'd0;
      n_checks++;
      if (bus_d.blip_out !== exp_o)
        $display("FAIL decay_out e=%0d got %0d want %0d", e, bus_d.blip_out, exp_o);
      else n_pass++;
    end
    n_checks++;
    if (bus_d.state_dbg !== DONE) $display("FAIL decay_state got %0d want %0d (DONE)", bus_d.state_dbg, DONE);
    else n_pass++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_and_hold();
    test_repeat();
    test_note_change();
    test_enable();
    test_reset_mid();
    test_level_zero();
`ifdef BLIP_DECAY_EN
    test_decay();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
